// File: rtl/demux1x2_buf_pkg.sv
// Shared encodings for the 1-to-2 buffered demux: buffer occupancy states and destination codes.
package demux1x2_buf_pkg;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;
    localparam logic [1:0] OCC_ILL   = 2'd3;

    localparam logic DST_B = 1'b0;
    localparam logic DST_C = 1'b1;

endpackage

// File: rtl/demux1x2_buf_out_buf.sv
// Two-entry output buffer with push counter; head visible one cycle after a push into EMPTY.
// Full flag is registered-state only, so the upstream ready never sees the sink ready combinationally.
module demux_out_buf
    import demux1x2_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_dat,
    input  logic                  pop_rdy,
    output logic [DATA_WIDTH-1:0] dat,
    output logic                  vld,
    output logic                  full,
    output logic [CNT_WIDTH-1:0]  cnt
);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] second;
    logic                  pop;

    assign pop = (state != OCC_EMPTY) && pop_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= OCC_EMPTY;
        end else begin
            state <= state_nxt;
            assert (state_nxt != OCC_ILL);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            OCC_EMPTY: if (push) state_nxt = OCC_ONE;
            OCC_ONE: begin
                if (push && !pop)      state_nxt = OCC_FULL;
                else if (!push && pop) state_nxt = OCC_EMPTY;
            end
            OCC_FULL:  if (pop) state_nxt = OCC_ONE;
            default:   state_nxt = OCC_ILL;
        endcase
    end

    // When push and pop coincide in ONE, the incoming word replaces the departing head.
    always_ff @(posedge clk) begin
        if (rst) begin
            head   <= '0;
            second <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                OCC_EMPTY: if (push) head <= push_dat;
                OCC_ONE: begin
                    if (push && pop) head   <= push_dat;
                    else if (push)   second <= push_dat;
                end
                OCC_FULL:  if (pop) head <= second;
                default: ;
            endcase
            if (push) cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        dat  = head;
        vld  = (state != OCC_EMPTY);
        full = (state == OCC_FULL);
    end

endmodule

// File: rtl/demux1x2_buf.sv
// Steers each accepted word to buffer B or C by sel; one-cycle latency into an empty buffer.
// ready_o depends only on sel, reset and registered fullness of the selected buffer.
module demux1x2_buf
    import demux1x2_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic                  valid_i,
    input  logic                  sel,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] b_o,
    output logic                  b_valid_o,
    input  logic                  b_ready_i,
    output logic [DATA_WIDTH-1:0] c_o,
    output logic                  c_valid_o,
    input  logic                  c_ready_i,
    output logic [CNT_WIDTH-1:0]  b_cnt_o,
    output logic [CNT_WIDTH-1:0]  c_cnt_o
);

    logic b_full;
    logic c_full;
    logic push_b;
    logic push_c;

    assign ready_o = !rst_i && ((sel == DST_C) ? !c_full : !b_full);
    assign push_b  = valid_i && ready_o && (sel == DST_B);
    assign push_c  = valid_i && ready_o && (sel == DST_C);

    demux_out_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_buf_b (
        .clk      (clk_i),
        .rst      (rst_i),
        .push     (push_b),
        .push_dat (a_i),
        .pop_rdy  (b_ready_i),
        .dat      (b_o),
        .vld      (b_valid_o),
        .full     (b_full),
        .cnt      (b_cnt_o)
    );

    demux_out_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_buf_c (
        .clk      (clk_i),
        .rst      (rst_i),
        .push     (push_c),
        .push_dat (a_i),
        .pop_rdy  (c_ready_i),
        .dat      (c_o),
        .vld      (c_valid_o),
        .full     (c_full),
        .cnt      (c_cnt_o)
    );

endmodule

// File: tb/tb_demux1x2_buf.sv
// Directed bench for demux1x2_buf with hand-computed expectations.
module tb_demux1x2_buf;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] a_i;
    logic        valid_i;
    logic        sel;
    logic        ready_o;
    logic [15:0] b_o;
    logic        b_valid_o;
    logic        b_ready_i;
    logic [15:0] c_o;
    logic        c_valid_o;
    logic        c_ready_i;
    logic [7:0]  b_cnt_o;
    logic [7:0]  c_cnt_o;

    int n_chk = 0;
    int n_err = 0;

    demux1x2_buf #(.DATA_WIDTH(16), .CNT_WIDTH(8)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .a_i       (a_i),
        .valid_i   (valid_i),
        .sel       (sel),
        .ready_o   (ready_o),
        .b_o       (b_o),
        .b_valid_o (b_valid_o),
        .b_ready_i (b_ready_i),
        .c_o       (c_o),
        .c_valid_o (c_valid_o),
        .c_ready_i (c_ready_i),
        .b_cnt_o   (b_cnt_o),
        .c_cnt_o   (c_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i   = 1'b1;
        valid_i = 1'b0;
        step();
        step();
        rst_i = 1'b0;
        #1;
    endtask

    initial begin
        rst_i = 1'b1; valid_i = 1'b1; sel = 1'b0; a_i = 16'h5555;
        b_ready_i = 1'b1; c_ready_i = 1'b1;

        // Reset held 3 cycles with valid and sink ready asserted
        repeat (3) step();
        chk("rst_ready",   ready_o,   0);
        chk("rst_bvalid",  b_valid_o, 0);
        chk("rst_cvalid",  c_valid_o, 0);
        chk("rst_bcnt",    b_cnt_o,   0);
        chk("rst_ccnt",    c_cnt_o,   0);
        chk("rst_bo",      b_o,       0);
        chk("rst_co",      c_o,       0);
        rst_i = 1'b0; valid_i = 1'b0;
        #1;
        chk("rel_ready", ready_o, 1);

        // Alternating stream, both sinks ready
        for (int i = 1; i <= 8; i++) begin
            a_i = 16'(i); sel = ((i % 2) == 0); valid_i = 1'b1;
            #1;
            chk("alt_ready", ready_o, 1);
            step();
            if ((i % 2) == 1) begin
                chk("alt_bvalid", b_valid_o, 1);
                chk("alt_bo",     b_o,       i);
            end else begin
                chk("alt_cvalid", c_valid_o, 1);
                chk("alt_co",     c_o,       i);
            end
        end
        valid_i = 1'b0;
        chk("alt_bcnt", b_cnt_o, 4);
        chk("alt_ccnt", c_cnt_o, 4);
        step();
        chk("alt_bdrain", b_valid_o, 0);
        chk("alt_cdrain", c_valid_o, 0);

        // Backpressure on B
        do_reset();
        b_ready_i = 1'b0; sel = 1'b0; valid_i = 1'b1; a_i = 16'hAAAA;
        #1;
        chk("bp_ready0", ready_o, 1);
        step();
        a_i = 16'hBBBB;
        #1;
        chk("bp_ready1", ready_o, 1);
        step();
        a_i = 16'hCCCC;
        #1;
        chk("bp_ready_full", ready_o, 0);
        step();
        chk("bp_hold_bo",  b_o,       16'hAAAA);
        chk("bp_hold_vld", b_valid_o, 1);
        chk("bp_hold_cnt", b_cnt_o,   2);
        b_ready_i = 1'b1;
        step();
        chk("bp_bo1", b_o, 16'hBBBB);
        step();
        valid_i = 1'b0;
        chk("bp_bo2",  b_o,       16'hCCCC);
        chk("bp_vld2", b_valid_o, 1);
        chk("bp_cnt",  b_cnt_o,   3);
        step();
        chk("bp_empty", b_valid_o, 0);

        // Independence: B full and stalled, C still accepts
        b_ready_i = 1'b0; sel = 1'b0; valid_i = 1'b1; a_i = 16'h0B01;
        step();
        a_i = 16'h0B02;
        step();
        valid_i = 1'b0;
        #1;
        chk("ind_ready_b", ready_o, 0);
        sel = 1'b1; a_i = 16'h1234; valid_i = 1'b1;
        #1;
        chk("ind_ready_c", ready_o, 1);
        step();
        valid_i = 1'b0;
        chk("ind_cvalid", c_valid_o, 1);
        chk("ind_co",     c_o,       16'h1234);
        chk("ind_bo",     b_o,       16'h0B01);
        b_ready_i = 1'b1;
        step();
        chk("ind_drain1", b_o, 16'h0B02);
        step();
        chk("ind_drain2", b_valid_o, 0);

        // Push and pop together while ONE
        b_ready_i = 1'b1; sel = 1'b0; valid_i = 1'b1; a_i = 16'h0011;
        step();
        chk("pp_bo1", b_o, 16'h0011);
        a_i = 16'h0022;
        step();
        valid_i = 1'b0;
        chk("pp_bo2",  b_o,       16'h0022);
        chk("pp_bvld", b_valid_o, 1);
        step();
        chk("pp_empty", b_valid_o, 0);

        // 256 pushes to C wrap its counter
        do_reset();
        c_ready_i = 1'b1; sel = 1'b1; valid_i = 1'b1;
        for (int k = 0; k < 255; k++) begin
            a_i = 16'(k);
            step();
        end
        chk("wrap_ff", c_cnt_o, 8'hFF);
        a_i = 16'hFFFF;
        step();
        valid_i = 1'b0;
        chk("wrap_00", c_cnt_o, 8'h00);
        chk("wrap_co", c_o,     16'hFFFF);

        // Reset while B is full discards buffered words
        b_ready_i = 1'b0; sel = 1'b0; valid_i = 1'b1; a_i = 16'hDEAD;
        step();
        a_i = 16'hBEEF;
        step();
        valid_i = 1'b0;
        chk("mr_full", b_valid_o, 1);
        rst_i = 1'b1; b_ready_i = 1'b1;
        step();
        chk("mr_bvalid", b_valid_o, 0);
        chk("mr_bcnt",   b_cnt_o,   0);
        chk("mr_ready",  ready_o,   0);
        rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("mr_no_stale", b_valid_o, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
